// File: rtl/mod_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod_divider_seq
//  Description : Sequential unsigned restoring divider. A rising edge on
//                start (while idle) latches the operands; the quotient is
//                then produced one bit per cycle, MSB first, over WIDTH
//                cycles. A zero divider completes after a single cycle with
//                quotient = all ones, remainder = dividend, div_by_zero = 1.
//
//  Ports       : clk         - clock, all state changes on rising edge
//                rst         - synchronous active-high reset
//                start       - request strobe (rising edge requests a divide)
//                dividend    - unsigned numerator, sampled on acceptance
//                divider     - unsigned denominator, sampled on acceptance
//                quotient    - unsigned result, held between completions
//                remainder   - unsigned result, held between completions
//                ready       - high when idle and results are valid
//                done        - one-cycle pulse on completion
//                div_by_zero - last accepted operation had divider == 0
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_divider_seq #(
    parameter int WIDTH = 16            // operand/result width, must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divider,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             done,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_start_q;
    logic [WIDTH-1:0]   r_divisor;
    // Holds the remaining dividend bits; vacated LSBs collect quotient bits.
    logic [WIDTH-1:0]   r_quot_sh;
    logic [WIDTH:0]     r_part;
    logic [c_cnt_w-1:0] r_count;

    logic               w_accept;
    logic [WIDTH+1:0]   w_trial;
    logic [WIDTH+1:0]   w_diff;
    logic               w_borrow;
    logic [WIDTH:0]     w_part_next;
    logic [WIDTH-1:0]   w_quot_next;

    // ready is only high in IDLE, so it doubles as the idle qualifier.
    assign w_accept = start & ~r_start_q & ready;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract. The trial is one bit wider than the stored remainder so a
    // failed subtraction shows up as a set MSB (borrow).
    assign w_trial     = {r_part, r_quot_sh[WIDTH-1]};
    assign w_diff      = w_trial - {2'b00, r_divisor};
    assign w_borrow    = w_diff[WIDTH+1];
    assign w_part_next = w_borrow ? w_trial[WIDTH:0] : w_diff[WIDTH:0];
    assign w_quot_next = {r_quot_sh[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_divisor   <= '0;
            r_quot_sh   <= '0;
            r_part      <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            r_start_q <= start;
            done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quot_sh   <= dividend;
                        r_divisor   <= divider;
                        r_part      <= '0;
                        r_count     <= '0;
                        div_by_zero <= 1'b0;
                        ready       <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (r_divisor == '0) begin
                        // Dividend is still untouched in the shift register
                        // on the first RUN cycle.
                        quotient    <= '1;
                        remainder   <= r_quot_sh;
                        div_by_zero <= 1'b1;
                        ready       <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_part    <= w_part_next;
                        r_quot_sh <= w_quot_next;
                        r_count   <= r_count + c_cnt_w'(1);
                        if (r_count == c_last) begin
                            quotient  <= w_quot_next;
                            remainder <= w_part_next[WIDTH-1:0];
                            ready     <= 1'b1;
                            done      <= 1'b1;
                            r_count   <= '0;
                            r_state   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
